// File: rtl/ads_frame_parser_if.sv
// Sample stream from the ADS frame parser toward the DMA/packetizer.
// The parser drives the master side; the consumer drives tready.
interface ads_frame_parser_if;
  logic [31:0] tdata;
  logic [3:0]  tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);
endinterface

// File: rtl/ads_frame_parser.sv
// Parses ADS129x DRDY frames (header + NUM_CH samples) into a commit-on-complete FIFO.
// Stream valid 2 cycles after the final frame byte; output holds while tready=0, frames dropped if no space.
module ads_frame_parser #(
  parameter int          NUM_CH     = 8,
  parameter int          FIFO_DEPTH = 32,
  parameter logic [3:0]  HDR_SYNC   = 4'hC
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               enable,
  input  logic               s_byte_valid,
  input  logic [7:0]         s_byte_data,
  input  logic               s_frame_start,
  ads_frame_parser_if.master m_axis,
  output logic [23:0]        status_word,
  output logic [31:0]        frame_cnt,
  output logic [15:0]        err_hdr_cnt,
  output logic [15:0]        err_ovf_cnt,
  output logic [15:0]        err_short_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, HDR, SAMP, DROP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  ch_q, ch_d;
  logic [15:0] shreg_q, shreg_d;
  logic [23:0] status_q, status_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_hdr_q, err_hdr_d, err_ovf_q, err_ovf_d, err_short_q, err_short_d;
  logic [PW-1:0] wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
  logic        commit_pend_q, commit_pend_d;
  logic        out_vld_q, out_vld_d;
  logic [36:0] out_dat_q, out_dat_d;

  logic [36:0] mem [FIFO_DEPTH];
  logic        wr_en;
  logic [36:0] wr_dat;
  logic [23:0] word;
  logic [PW-1:0] used;
  logic [PW:0] free;
  logic        last_ch;
  logic        mid_frame;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign word      = {shreg_q, s_byte_data};
  assign used      = wr_q - rd_q;
  assign free      = (PW+1)'(FIFO_DEPTH) - {1'b0, used};
  assign last_ch   = (ch_q == 4'(NUM_CH - 1));
  assign mid_frame = (state_q == HDR) || (state_q == SAMP);
  assign wr_dat    = {last_ch, ch_q, {8{word[23]}}, word};

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    ch_d          = ch_q;
    shreg_d       = shreg_q;
    status_d      = status_q;
    frame_cnt_d   = frame_cnt_q;
    err_hdr_d     = err_hdr_q;
    err_ovf_d     = err_ovf_q;
    err_short_d   = err_short_q;
    wr_d          = wr_q;
    commit_pend_d = 1'b0;
    // Commit lands one cycle after the last sample write so the read side sees whole frames only.
    commit_d      = commit_pend_q ? wr_q : commit_q;
    wr_en         = 1'b0;

    if (!enable) begin
      if (mid_frame) wr_d = commit_q;
      state_d = IDLE;
    end else if (s_byte_valid) begin
      if (s_frame_start) begin
        if (mid_frame) begin
          wr_d        = commit_q;
          err_short_d = sat_inc(err_short_q);
        end
        state_d    = HDR;
        byte_cnt_d = 2'd1;
        shreg_d    = {8'h00, s_byte_data};
      end else begin
        case (state_q)
          HDR: begin
            if (byte_cnt_q == 2'd2) begin
              if (word[23:20] != HDR_SYNC) begin
                err_hdr_d = sat_inc(err_hdr_q);
                state_d   = DROP;
              end else if (free < (PW+1)'(NUM_CH)) begin
                status_d  = word;
                err_ovf_d = sat_inc(err_ovf_q);
                state_d   = DROP;
              end else begin
                status_d   = word;
                ch_d       = 4'd0;
                byte_cnt_d = 2'd0;
                state_d    = SAMP;
              end
            end else begin
              shreg_d    = {shreg_q[7:0], s_byte_data};
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          SAMP: begin
            if (byte_cnt_q == 2'd2) begin
              wr_en      = 1'b1;
              wr_d       = wr_q + 1'b1;
              byte_cnt_d = 2'd0;
              if (last_ch) begin
                commit_pend_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 32'd1;
                state_d       = IDLE;
              end else begin
                ch_d = ch_q + 4'd1;
              end
            end else begin
              shreg_d    = {shreg_q[7:0], s_byte_data};
              byte_cnt_d = byte_cnt_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_d      = rd_q;
    out_vld_d = out_vld_q;
    out_dat_d = out_dat_q;
    if (!out_vld_q || m_axis.tready) begin
      if (rd_q != commit_q) begin
        out_vld_d = 1'b1;
        out_dat_d = mem[rd_q[AW-1:0]];
        rd_d      = rd_q + 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_en) mem[wr_q[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      ch_q          <= '0;
      shreg_q       <= '0;
      status_q      <= '0;
      frame_cnt_q   <= '0;
      err_hdr_q     <= '0;
      err_ovf_q     <= '0;
      err_short_q   <= '0;
      wr_q          <= '0;
      commit_q      <= '0;
      rd_q          <= '0;
      commit_pend_q <= 1'b0;
      out_vld_q     <= 1'b0;
      out_dat_q     <= '0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      ch_q          <= ch_d;
      shreg_q       <= shreg_d;
      status_q      <= status_d;
      frame_cnt_q   <= frame_cnt_d;
      err_hdr_q     <= err_hdr_d;
      err_ovf_q     <= err_ovf_d;
      err_short_q   <= err_short_d;
      wr_q          <= wr_d;
      commit_q      <= commit_d;
      rd_q          <= rd_d;
      commit_pend_q <= commit_pend_d;
      out_vld_q     <= out_vld_d;
      out_dat_q     <= out_dat_d;
    end
  end

  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tdata  = out_dat_q[31:0];
  assign m_axis.tuser  = out_dat_q[35:32];
  assign m_axis.tlast  = out_dat_q[36];
  assign status_word   = status_q;
  assign frame_cnt     = frame_cnt_q;
  assign err_hdr_cnt   = err_hdr_q;
  assign err_ovf_cnt   = err_ovf_q;
  assign err_short_cnt = err_short_q;

endmodule

// File: tb/tb_ads_frame_parser.sv
// Directed bench for ads_frame_parser: frames in, expected beats queued, stream checked on negedge.
module tb_ads_frame_parser;
  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        enable = 1'b0;
  logic        s_byte_valid = 1'b0;
  logic [7:0]  s_byte_data = 8'h00;
  logic        s_frame_start = 1'b0;
  logic [23:0] status_word;
  logic [31:0] frame_cnt;
  logic [15:0] err_hdr_cnt, err_ovf_cnt, err_short_cnt;

  ads_frame_parser_if axis_if ();

  always #5 ACLK = ~ACLK;

  ads_frame_parser #(.NUM_CH(8), .FIFO_DEPTH(32), .HDR_SYNC(4'hC)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .enable        (enable),
    .s_byte_valid  (s_byte_valid),
    .s_byte_data   (s_byte_data),
    .s_frame_start (s_frame_start),
    .m_axis        (axis_if),
    .status_word   (status_word),
    .frame_cnt     (frame_cnt),
    .err_hdr_cnt   (err_hdr_cnt),
    .err_ovf_cnt   (err_ovf_cnt),
    .err_short_cnt (err_short_cnt)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  u;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          ncmp = 0;
  int          nmis = 0;
  int          beats = 0;
  int          lasts = 0;
  int          base;
  logic [23:0] samp [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    s_byte_valid  = 1'b1;
    s_byte_data   = b;
    s_frame_start = fs;
    tick(1);
    s_byte_valid  = 1'b0;
    s_frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [23:0] w, input logic fs);
    send_byte(w[23:16], fs);
    send_byte(w[15:8], 1'b0);
    send_byte(w[7:0], 1'b0);
  endtask

  task automatic send_frame(input logic [23:0] hdr, input int nsamp);
    send_word(hdr, 1'b1);
    for (int i = 0; i < nsamp; i++) send_word(samp[i], 1'b0);
  endtask

  task automatic push_frame();
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.d = {{8{samp[i][23]}}, samp[i]};
      b.u = 4'(i);
      b.l = (i == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic rand_samp();
    for (int i = 0; i < 8; i++) samp[i] = 24'($urandom);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 32'(axis_if.tvalid), 32'd0);
    check({tag, "_tdata"}, axis_if.tdata, 32'd0);
    check({tag, "_tuser"}, 32'(axis_if.tuser), 32'd0);
    check({tag, "_tlast"}, 32'(axis_if.tlast), 32'd0);
    check({tag, "_status"}, 32'(status_word), 32'd0);
    check({tag, "_frame_cnt"}, frame_cnt, 32'd0);
    check({tag, "_err_hdr"}, 32'(err_hdr_cnt), 32'd0);
    check({tag, "_err_ovf"}, 32'(err_ovf_cnt), 32'd0);
    check({tag, "_err_short"}, 32'(err_short_cnt), 32'd0);
  endtask

  always @(negedge ACLK) begin
    if (ARESETN && axis_if.tvalid && axis_if.tready) begin
      beats++;
      if (axis_if.tlast) lasts++;
      ncmp++;
      assert (exp_q.size() != 0) else begin
        nmis++;
        $error("FAIL unexpected_beat: observed tdata %h tuser %0d, expected no beat", axis_if.tdata, axis_if.tuser);
      end
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_tdata", axis_if.tdata, e.d);
        check("beat_tuser", 32'(axis_if.tuser), 32'(e.u));
        check("beat_tlast", 32'(axis_if.tlast), 32'(e.l));
      end
    end
  end

  initial begin
    axis_if.tready = 1'b0;
    tick(3);
    check_zero("reset");
    ARESETN = 1'b1;
    enable = 1'b1;
    axis_if.tready = 1'b1;
    tick(2);

    // Good frame with sign-extension corners and latency check
    samp = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'hFFFFFF,
             24'h123456, 24'h000000, 24'h400000, 24'hC00000};
    push_frame();
    send_frame(24'hC00000, 8);
    check("lat_edge0", 32'(axis_if.tvalid), 32'd0);
    tick(1);
    check("lat_edge1", 32'(axis_if.tvalid), 32'd0);
    tick(1);
    check("lat_edge2", 32'(axis_if.tvalid), 32'd1);
    tick(12);
    check("good_beats", beats, 8);
    check("good_lasts", lasts, 1);
    check("good_frame_cnt", frame_cnt, 32'd1);
    check("good_status", 32'(status_word), 32'h00C00000);

    // Bad header, then a good frame
    rand_samp();
    send_frame(24'h800000, 8);
    tick(4);
    check("badhdr_tvalid", 32'(axis_if.tvalid), 32'd0);
    check("badhdr_err", 32'(err_hdr_cnt), 32'd1);
    check("badhdr_beats", beats, 8);
    rand_samp();
    push_frame();
    send_frame(24'hCA5A5A, 8);
    tick(12);
    check("afterbad_beats", beats, 16);
    check("afterbad_frame_cnt", frame_cnt, 32'd2);
    check("afterbad_status", 32'(status_word), 32'h00CA5A5A);

    // Backpressure fills FIFO; fifth frame overflows
    axis_if.tready = 1'b0;
    for (int f = 0; f < 5; f++) begin
      rand_samp();
      if (f < 4) push_frame();
      send_frame((f == 4) ? 24'hC12345 : (24'hC00000 | 24'(f)), 8);
    end
    tick(4);
    check("ovf_err", 32'(err_ovf_cnt), 32'd1);
    check("ovf_status", 32'(status_word), 32'h00C12345);
    check("ovf_frame_cnt", frame_cnt, 32'd6);
    check("ovf_tvalid_held", 32'(axis_if.tvalid), 32'd1);
    axis_if.tready = 1'b1;
    tick(40);
    check("ovf_drain_beats", beats, 48);
    check("ovf_drain_lasts", lasts, 6);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);

    // Short frame aborted by an early frame_start
    rand_samp();
    send_frame(24'hC00000, 4);
    rand_samp();
    push_frame();
    send_frame(24'hC00001, 8);
    tick(12);
    check("short_err", 32'(err_short_cnt), 32'd1);
    check("short_frame_cnt", frame_cnt, 32'd7);
    check("short_beats", beats, 56);
    check("short_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset after 10 bytes of a frame
    rand_samp();
    send_word(24'hC00000, 1'b1);
    send_word(samp[0], 1'b0);
    send_word(samp[1], 1'b0);
    send_byte(samp[2][23:16], 1'b0);
    ARESETN = 1'b0;
    #1;
    check_zero("midrst");
    tick(2);
    ARESETN = 1'b1;
    tick(2);
    check("postrst_tvalid", 32'(axis_if.tvalid), 32'd0);
    base = beats;
    rand_samp();
    push_frame();
    send_frame(24'hC00000, 8);
    tick(12);
    check("postrst_beats", beats, base + 8);
    check("postrst_frame_cnt", frame_cnt, 32'd1);
    check("postrst_queue_empty", 32'(exp_q.size()), 32'd0);

    // enable dropped mid-frame with one committed frame pending
    axis_if.tready = 1'b0;
    base = beats;
    rand_samp();
    push_frame();
    send_frame(24'hC00000, 8);
    rand_samp();
    send_frame(24'hC00000, 2);
    enable = 1'b0;
    axis_if.tready = 1'b1;
    tick(14);
    check("en_drain_beats", beats, base + 8);
    check("en_frame_cnt", frame_cnt, 32'd2);
    check("en_err_short", 32'(err_short_cnt), 32'd0);
    check("en_err_hdr", 32'(err_hdr_cnt), 32'd0);
    check("en_err_ovf", 32'(err_ovf_cnt), 32'd0);
    check("en_queue_empty", 32'(exp_q.size()), 32'd0);
    enable = 1'b1;
    tick(1);
    rand_samp();
    push_frame();
    send_frame(24'hC0FFFF, 8);
    tick(12);
    check("reen_beats", beats, base + 16);
    check("reen_frame_cnt", frame_cnt, 32'd3);
    check("reen_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
